// File: rtl/pwm_pkg.sv
// Shared constants and sizing helpers for the multi-channel PWM block.
// Counter range, channel-index width and reset levels live here so every file agrees.
package pwm_pkg;

    // Reset levels of the registered outputs (pulse therefore resets to pol).
    localparam logic RST_PULSE  = 1'b0;
    localparam logic RST_STROBE = 1'b0;

    // Largest duty value; the period counter runs 0..cnt_max-1.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Duty-write bus between the register/control logic (master) and the PWM block (slave).
// One wr_en pulse per write; wr_ch selects the channel, wr_duty carries the new value.
interface pwm_if
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_duty;

    modport master (output wr_en, wr_ch, wr_duty);
    modport slave  (input  wr_en, wr_ch, wr_duty);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock-enable generator for the PWM period counter: one tick every prescale+1 clocks.
// Held at zero while enable is low so a restart always begins on a fresh prescale interval.
module pwm_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    // A count left above a freshly lowered prescale is treated as a hit, so it wraps at once
    // instead of running on to overflow.
    assign tick = enable && (pcnt >= prescale);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!enable || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, per-channel double-buffered duty, polarity and
// a period_start strobe. Duty writes land in a pending buffer and go live at the period boundary.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CHANNELS-1:0]   pol,
    pwm_if.slave                  wr,
    output logic [CHANNELS-1:0]   pulse,
    output logic                  period_start
);

    localparam int               CH_W     = ch_idx_w(CHANNELS);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(cnt_max(WIDTH) - 1);

    logic             tick;
    logic             boundary;
    logic             wr_valid;
    logic             enable_d;
    logic [WIDTH-1:0] cnt;

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    assign boundary = tick && (cnt == CNT_LAST);

    // With a power-of-two channel count every index is legal, so no range check is needed.
    if (CHANNELS == (1 << CH_W)) begin : g_ch_full
        assign wr_valid = wr.wr_en;
    end else begin : g_ch_part
        assign wr_valid = wr.wr_en && (wr.wr_ch < CH_W'(CHANNELS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || boundary) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Strobe after every boundary and after every enable rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_d     <= 1'b0;
            period_start <= RST_STROBE;
        end else begin
            enable_d     <= enable;
            period_start <= boundary || (enable && !enable_d);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] pending;
        logic [WIDTH-1:0] active;
        logic             pulse_reg;
        logic             wr_hit;

        assign wr_hit = wr_valid && (wr.wr_ch == CH_W'(i));

        // NOTE: the duty buffers are a handful of flops, not a RAM, so they take the async
        // reset like any other state and a reset never leaves a stale duty behind.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending   <= '0;
                active    <= '0;
                pulse_reg <= RST_PULSE;
            end else begin
                if (wr_hit) begin
                    pending <= wr.wr_duty;
                end
                // A write on the boundary (or while idle) bypasses the shadow stage.
                if (wr_hit && (boundary || !enable)) begin
                    active <= wr.wr_duty;
                end else if (boundary) begin
                    active <= pending;
                end
                pulse_reg <= enable && (cnt < active);
            end
        end

        assign pulse[i] = pulse_reg ^ pol[i];
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: a cycle-level reference model feeds a scoreboard queue that
// a negedge monitor drains, plus period measurements of high time and period length.
module tb_pwm_multi;

    localparam int CHANNELS   = 4;
    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 8;
    localparam int CNT_MAX    = (1 << WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic [CHANNELS-1:0]   pol = 4'b0101;
    logic [CHANNELS-1:0]   pulse;
    logic                  period_start;

    pwm_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) wr_bus ();

    pwm_multi #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .prescale     (prescale),
        .pol          (pol),
        .wr           (wr_bus),
        .pulse        (pulse),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as plain integers, stepped once per rising edge from the rules.
    typedef struct packed {
        logic [CHANNELS-1:0] preg;
        logic                ps;
    } exp_t;

    exp_t                sb_q[$];
    int                  m_pcnt, m_cnt;
    int                  m_pend[CHANNELS];
    int                  m_act[CHANNELS];
    logic [CHANNELS-1:0] m_preg;
    logic                m_ps, m_en_d;

    always @(posedge clk) begin
        bit                  tk, bnd;
        logic [CHANNELS-1:0] nxt;
        if (!rst_n) begin
            m_pcnt = 0;
            m_cnt  = 0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
            m_preg = '0;
            m_ps   = 1'b0;
            m_en_d = 1'b0;
        end else begin
            tk  = enable && (m_pcnt >= int'(prescale));
            bnd = tk && (m_cnt == CNT_MAX - 1);
            for (int i = 0; i < CHANNELS; i++) nxt[i] = enable && (m_cnt < m_act[i]);
            if (bnd) for (int i = 0; i < CHANNELS; i++) m_act[i] = m_pend[i];
            if (wr_bus.wr_en && int'(wr_bus.wr_ch) < CHANNELS) begin
                m_pend[wr_bus.wr_ch] = int'(wr_bus.wr_duty);
                if (bnd || !enable) m_act[wr_bus.wr_ch] = int'(wr_bus.wr_duty);
            end
            m_ps   = bnd || (enable && !m_en_d);
            m_en_d = enable;
            m_pcnt = (!enable || tk) ? 0 : m_pcnt + 1;
            m_cnt  = (!enable || bnd) ? 0 : (tk ? m_cnt + 1 : m_cnt);
            m_preg = nxt;
        end
        sb_q.push_back('{preg: m_preg, ps: m_ps});
    end

    // Monitor: one expectation per cycle; an asserted reset forces the reset outputs at once.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (!rst_n) e = '0;
            check("sb_pulse", pulse, e.preg ^ pol);
            check("sb_period_start", period_start, e.ps);
        end
    end

    int m_len;
    int m_hi[CHANNELS];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_ch   = ch[1:0];
        wr_bus.wr_duty = d[WIDTH-1:0];
        @(posedge clk);
        #1;
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic wait_cnt(input int v, input bit need_tick, input int budget);
        int n = 0;
        while (!(m_cnt == v && (!need_tick || m_pcnt >= int'(prescale)))) begin
            @(posedge clk);
            #1;
            n++;
            if (n > budget) begin
                check("wait_cnt_timeout", 0, 1);
                return;
            end
        end
    endtask

    // Measures one period window: the cycles after a period_start up to and including the next.
    task automatic measure(input bit started);
        int n = 0;
        m_len = 0;
        for (int i = 0; i < CHANNELS; i++) m_hi[i] = 0;
        if (!started) begin
            do begin
                @(negedge clk);
                n++;
                if (n > 5000) begin
                    check("period_start_timeout", 0, 1);
                    return;
                end
            end while (!period_start);
        end
        do begin
            @(negedge clk);
            m_len++;
            for (int i = 0; i < CHANNELS; i++) if (pulse[i] ^ pol[i]) m_hi[i]++;
            if (m_len > 5000) begin
                check("period_len_timeout", 0, 1);
                return;
            end
        end while (!period_start);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_ch   = '0;
        wr_bus.wr_duty = '0;

        // Reset and idle
        step(3);
        check("rst_pulse", pulse, 4'b0101);
        check("rst_period_start", period_start, 0);
        rst_n = 1'b1;
        step(3);
        check("idle_pulse", pulse, 4'b0101);

        // Duties loaded while idle go live immediately
        wr(0, 64);
        wr(1, 0);
        wr(2, 255);
        wr(3, 128);
        enable = 1'b1;
        step(1);
        check("enable_period_start", period_start, 1);
        measure(0);
        measure(1);
        check("sweep_len", m_len, 255);
        check("sweep_hi0", m_hi[0], 64);
        check("zero_hi1", m_hi[1], 0);
        check("full_hi2", m_hi[2], 255);
        check("mid_hi3", m_hi[3], 128);
        measure(1);
        check("zero_hi1_p3", m_hi[1], 0);
        check("full_hi2_p3", m_hi[2], 255);

        // Shadowing: a mid-period write waits for the boundary, a boundary write bypasses
        wr(0, 100);
        measure(0);
        check("shadow_hi_100", m_hi[0], 100);
        fork
            measure(1);
            begin
                @(posedge clk);
                #1;
                wait_cnt(50, 1'b0, 2000);
                wr(0, 30);
            end
        join
        check("shadow_cur_100", m_hi[0], 100);
        fork
            measure(1);
            begin
                @(posedge clk);
                #1;
                wait_cnt(CNT_MAX - 1, 1'b1, 2000);
                wr(0, 200);
            end
        join
        check("shadow_next_30", m_hi[0], 30);
        measure(1);
        check("bypass_200", m_hi[0], 200);

        // Prescale
        prescale = 8'd3;
        wr(0, 10);
        measure(0);
        check("presc_len", m_len, 1020);
        check("presc_hi0", m_hi[0], 40);
        fork
            measure(1);
            begin
                @(posedge clk);
                #1;
                wait_cnt(100, 1'b0, 5000);
                prescale = 8'd0;
            end
        join
        check("presc_change_len_in_range", (m_len > 255 && m_len < 1020) ? 1 : 0, 1);
        measure(1);
        check("presc_after_len", m_len, 255);
        check("presc_after_hi0", m_hi[0], 10);

        // Randomised traffic, checked cycle by cycle by the scoreboard
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            wr_bus.wr_en   = ($urandom_range(0, 7) == 0);
            wr_bus.wr_ch   = 2'($urandom_range(0, CHANNELS - 1));
            case ($urandom_range(0, 3))
                0:       wr_bus.wr_duty = '0;
                1:       wr_bus.wr_duty = 8'(CNT_MAX);
                default: wr_bus.wr_duty = 8'($urandom);
            endcase
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) pol = 4'($urandom);
            if ($urandom_range(0, 499) == 0) prescale = 8'($urandom_range(0, 2));
            @(posedge clk);
            #1;
        end
        wr_bus.wr_en = 1'b0;
        prescale     = 8'd0;
        pol          = 4'b0101;
        enable       = 1'b1;

        // Asynchronous reset mid-period
        wait_cnt(120, 1'b0, 3000);
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", pulse, 4'b0101);
        check("async_rst_period_start", period_start, 0);
        enable = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        check("post_rst_idle_pulse", pulse, 4'b0101);
        enable = 1'b1;
        step(1);
        check("post_rst_enable_period_start", period_start, 1);
        @(negedge clk);
        measure(1);
        for (int i = 0; i < CHANNELS; i++) check("post_rst_duty_zero", m_hi[i], 0);
        measure(1);
        check("post_rst_len", m_len, 255);
        check("post_rst_hi0", m_hi[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
